// File: rtl/adder_trojan_checker_if.sv
// Pin-level link between the trojan checker (master) and the adder under test (slave).
interface adder_trojan_checker_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_cin;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;

  modport master (output dut_a, dut_b, dut_cin, input dut_sum, dut_cout);
  modport slave  (input dut_a, dut_b, dut_cin, output dut_sum, dut_cout);
endinterface

// File: rtl/adder_trojan_checker.sv
// Exhaustive stimulus/response harness for a WIDTH-bit adder: sweeps every {a,b,cin},
// compares against a golden sum and reports pass, mismatch count and first failing vector.
module adder_trojan_checker #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  adder_trojan_checker_if.master dut,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_CNT_W-1:0]   err_count,
  output logic [2*WIDTH:0]       first_fail_vec,
  output logic                   first_fail_valid
);

  localparam int VW    = 2 * WIDTH + 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [VW-1:0]        VEC_LAST    = {VW{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_MAX     = {ERR_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [WIDTH:0] golden_sum(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             cin);
    golden_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  endfunction

  state_t               state_q, state_d;
  logic [VW-1:0]        vec_q, vec_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 cin_q, cin_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [VW-1:0]        ffv_q, ffv_d;
  logic                 ffvalid_q, ffvalid_d;
  logic [VW-1:0]        vec_inc;
  logic                 mismatch;

  assign vec_inc  = vec_q + {{(VW-1){1'b0}}, 1'b1};
  // dut_* are the registered decode of vec_q, so they double as the golden operands
  assign mismatch = golden_sum(a_q, b_q, cin_q) != {dut.dut_cout, dut.dut_sum};

  // Sweep sequencing, response comparison and result bookkeeping
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    settle_d  = settle_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    case (state_q)
      S_IDLE: begin
        a_d   = {WIDTH{1'b0}};
        b_d   = {WIDTH{1'b0}};
        cin_d = 1'b0;
        if (start) begin
          state_d   = S_APPLY;
          vec_d     = {VW{1'b0}};
          settle_d  = {SET_W{1'b0}};
          busy_d    = 1'b1;
          pass_d    = 1'b0;
          err_d     = {ERR_CNT_W{1'b0}};
          ffv_d     = {VW{1'b0}};
          ffvalid_d = 1'b0;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = S_CHECK;
          settle_d = {SET_W{1'b0}};
        end else begin
          settle_d = settle_q + {{(SET_W-1){1'b0}}, 1'b1};
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
          end else begin
            err_d = err_q;
          end
          if (!ffvalid_q) begin
            ffv_d     = vec_q;
            ffvalid_d = 1'b1;
          end else begin
            ffv_d = ffv_q;
          end
        end else begin
          err_d = err_q;
        end
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == {ERR_CNT_W{1'b0}});
          a_d     = {WIDTH{1'b0}};
          b_d     = {WIDTH{1'b0}};
          cin_d   = 1'b0;
        end else begin
          state_d = S_APPLY;
          vec_d   = vec_inc;
          a_d     = vec_inc[2*WIDTH:WIDTH+1];
          b_d     = vec_inc[WIDTH:1];
          cin_d   = vec_inc[0];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        a_d     = {WIDTH{1'b0}};
        b_d     = {WIDTH{1'b0}};
        cin_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vec_q     <= {VW{1'b0}};
      settle_q  <= {SET_W{1'b0}};
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      cin_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= {ERR_CNT_W{1'b0}};
      ffv_q     <= {VW{1'b0}};
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      settle_q  <= settle_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  assign dut.dut_a      = a_q;
  assign dut.dut_b      = b_q;
  assign dut.dut_cin    = cin_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_adder_trojan_checker.sv
// Scoreboard bench: three checker instances (default, ERR_CNT_W=4, SETTLE_CYCLES=3) drive
// a behavioural adder with selectable faults; expected sweep results come from plain arithmetic.
module tb_adder_trojan_checker;
  localparam int N = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int mode = 0;
  int stuck_bit = 0;
  int total = 0;
  int bad = 0;
  int dones = 0;
  int nsweeps = 0;

  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
  logic [9:0] err0, err2;
  logic [3:0] err1;
  logic [8:0] ffv0, ffv1, ffv2;
  logic ffval0, ffval1, ffval2;

  adder_trojan_checker_if #(.WIDTH(4)) bus0 ();
  adder_trojan_checker_if #(.WIDTH(4)) bus1 ();
  adder_trojan_checker_if #(.WIDTH(4)) bus2 ();

  // Adder under test: 0 golden, 1 carry into bit 2 forced high, 2 cout stuck-at-0, 3 one sum bit stuck-at-1
  function automatic logic [4:0] aut(input int m, input int sb, input logic [3:0] a,
                                     input logic [3:0] b, input logic cin);
    int g, lo, hi, r;
    g = int'(a) + int'(b) + int'(cin);
    case (m)
      1: begin
        lo = int'(a) % 4 + int'(b) % 4 + int'(cin);
        hi = int'(a) / 4 + int'(b) / 4 + 1;
        r  = hi * 4 + lo % 4;
      end
      2:       r = g % 16;
      3:       r = g | (1 << sb);
      default: r = g;
    endcase
    return 5'(r);
  endfunction

  assign {bus0.dut_cout, bus0.dut_sum} = aut(mode, stuck_bit, bus0.dut_a, bus0.dut_b, bus0.dut_cin);
  assign {bus1.dut_cout, bus1.dut_sum} = aut(mode, stuck_bit, bus1.dut_a, bus1.dut_b, bus1.dut_cin);
  assign {bus2.dut_cout, bus2.dut_sum} = aut(mode, stuck_bit, bus2.dut_a, bus2.dut_b, bus2.dut_cin);

  adder_trojan_checker u0 (.clk(clk), .rst(rst), .start(start0), .dut(bus0.master),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(ffv0), .first_fail_valid(ffval0));
  adder_trojan_checker #(.ERR_CNT_W(4)) u1 (.clk(clk), .rst(rst), .start(start1), .dut(bus1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1));
  adder_trojan_checker #(.SETTLE_CYCLES(3)) u2 (.clk(clk), .rst(rst), .start(start2), .dut(bus2.master),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_vec(ffv2), .first_fail_valid(ffval2));

  typedef struct {
    int     inst;
    longint done_cyc;
    int     pass;
    int     err;
    int     ffv;
    int     ffval;
  } exp_t;

  exp_t sbq[$];

  task automatic cmp(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: count vectors where the adder differs from a+b+cin, in index order
  function automatic exp_t predict(input int inst, input int m, input int sb, input int nvec);
    exp_t e;
    int a, b, c, cap;
    cap = (inst == 1) ? 15 : 1023;
    e.inst = inst; e.done_cyc = 0; e.err = 0; e.ffv = 0; e.ffval = 0;
    for (int v = 0; v < nvec; v++) begin
      a = v / 32; b = (v / 2) % 16; c = v % 2;
      if (int'(aut(m, sb, 4'(a), 4'(b), 1'(c))) != a + b + c) begin
        if (e.err < cap) e.err++;
        if (e.ffval == 0) begin
          e.ffv = v;
          e.ffval = 1;
        end
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  function automatic logic busy_of(input int inst);
    return (inst == 0) ? busy0 : (inst == 1) ? busy1 : busy2;
  endfunction
  function automatic logic pass_of(input int inst);
    return (inst == 0) ? pass0 : (inst == 1) ? pass1 : pass2;
  endfunction
  function automatic longint err_of(input int inst);
    return (inst == 0) ? longint'(err0) : (inst == 1) ? longint'(err1) : longint'(err2);
  endfunction

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic on_done(input int inst, input logic busy, input logic pass, input longint err,
                         input longint ffv, input logic ffval);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_done: instance %0d pulsed done at cycle %0d with no sweep pending", inst, cyc);
    end else begin
      e = sbq.pop_front();
      dones++;
      cmp("done_instance", inst, e.inst);
      cmp("done_cycle", cyc, e.done_cyc);
      cmp("busy_at_done", busy, 0);
      cmp("pass", pass, e.pass);
      cmp("err_count", err, e.err);
      cmp("first_fail_valid", ffval, e.ffval);
      if (e.ffval != 0) cmp("first_fail_vec", ffv, e.ffv);
    end
  endtask

  // Monitor: pops the scoreboard whenever any instance presents done
  always @(negedge clk) begin
    if (done0) on_done(0, busy0, pass0, longint'(err0), longint'(ffv0), ffval0);
    if (done1) on_done(1, busy1, pass1, longint'(err1), longint'(ffv1), ffval1);
    if (done2) on_done(2, busy2, pass2, longint'(err2), longint'(ffv2), ffval2);
  end

  task automatic run_sweep(input int inst, input int m, input int sb, input int rp1, input int rp2);
    exp_t e;
    int s, lim;
    bit fin;
    @(negedge clk);
    mode = m;
    stuck_bit = sb;
    s = (inst == 2) ? 3 : 1;
    e = predict(inst, m, sb, N);
    e.done_cyc = cyc + 1 + N * (s + 1);
    sbq.push_back(e);
    nsweeps++;
    set_start(inst, 1'b1);
    lim = N * (s + 1) + 20;
    fin = 1'b0;
    for (int k = 1; k <= lim && !fin; k++) begin
      @(negedge clk);
      set_start(inst, (k == rp1) || (k == rp2));
      if (sbq.size() == 0) fin = 1'b1;
    end
    set_start(inst, 1'b0);
    if (!fin) begin
      total++;
      bad++;
      $display("FAIL sweep_timeout: instance %0d gave no done within %0d cycles", inst, lim);
      sbq.delete();
    end
    repeat (4) @(negedge clk);
    cmp("busy_idle_after", busy_of(inst), 0);
    cmp("pass_hold", pass_of(inst), e.pass);
    cmp("err_hold", err_of(inst), e.err);
  endtask

  // Trojan sweep on instance 0 aborted by reset during cycle rc
  task automatic reset_mid(input int rc);
    exp_t e;
    int v;
    @(negedge clk);
    mode = 1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (rc - 1) @(negedge clk);
    v = (rc - 1) / 2;
    e = predict(0, 1, 0, v);
    cmp("mid_busy", busy0, 1);
    cmp("mid_err_count", err0, e.err);
    cmp("mid_dut_a", bus0.dut_a, v / 32);
    cmp("mid_dut_b", bus0.dut_b, (v / 2) % 16);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("rst_busy", busy0, 0);
    cmp("rst_done", done0, 0);
    cmp("rst_pass", pass0, 0);
    cmp("rst_err_count", err0, 0);
    cmp("rst_ffv", ffv0, 0);
    cmp("rst_ffvalid", ffval0, 0);
    cmp("rst_dut_bus", {bus0.dut_a, bus0.dut_b, bus0.dut_cin}, 0);
    repeat (5) @(negedge clk);
    cmp("rst_stays_idle", busy0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    cmp("reset_busy", busy0, 0);
    cmp("reset_done", done0, 0);
    cmp("reset_pass", pass0, 0);
    cmp("reset_err_count", err0, 0);
    cmp("reset_ffvalid", ffval0, 0);
    cmp("reset_dut_bus", {bus0.dut_a, bus0.dut_b, bus0.dut_cin}, 0);
    rst = 1'b0;

    run_sweep(0, 0, 0, 0, 0);
    run_sweep(0, 1, 0, 0, 0);
    run_sweep(0, 2, 0, 0, 0);
    run_sweep(1, 1, 0, 0, 0);
    run_sweep(2, 0, 0, 0, 0);
    run_sweep(0, 0, 0, 10, 500);

    reset_mid(300);
    run_sweep(0, 1, 0, 0, 0);

    @(negedge clk);
    rst = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    cmp("start_with_rst_lost", busy0, 0);

    reset_mid($urandom_range(3, 1000));
    for (int i = 0; i < 4; i++) begin
      run_sweep($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 4),
                $urandom_range(2, 1000), 0);
    end

    repeat (4) @(negedge clk);
    cmp("done_count", dones, nsweeps);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
